// File: rtl/ctrl_pipe.sv
// ctrl_pipe: two-stage (EX, WB) instruction control pipeline for a small
// register-file datapath. Decodes an accepted instruction into register
// read/write enables, operand/zero selects, function-unit truth-table codes
// (L/M/N), shifter controls and A/B forwarding flags.
// Shifts (SHL/SHR with shamt > 0) stay in EX for shamt cycles. During that
// time the shifter output is fed back in place of the register A read.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       instruction handshake
//   opcode, opsel, shamt      instruction fields
//   aaddr, baddr, waddr       A-read, B-read and write register addresses
//   ARdEn, BRdEn, WriteEn     one-hot (or zero) register enables
//   FBEn                      shifter feedback select
//   L, M, N                   function-unit truth-table codes
//   ASelect..zeroSelect       operand-source selects
//   shl, shr                  shifter direction strobes
//   fwdA, fwdB                WB-to-EX forwarding flags
//   busy                      EX or WB holds a valid instruction
module ctrl_pipe #(
  parameter int NREGS = 4,
  parameter int SHW   = 3,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [1:0]       opsel,
  input  logic [AW-1:0]    aaddr,
  input  logic [AW-1:0]    baddr,
  input  logic [AW-1:0]    waddr,
  input  logic [SHW-1:0]   shamt,
  output logic [NREGS-1:0] ARdEn,
  output logic [NREGS-1:0] BRdEn,
  output logic [NREGS-1:0] WriteEn,
  output logic             FBEn,
  output logic [3:0]       L,
  output logic [3:0]       M,
  output logic [3:0]       N,
  output logic             ASelect,
  output logic             BSelect,
  output logic             DSelect,
  output logic             zeroSelect,
  output logic             shl,
  output logic             shr,
  output logic             fwdA,
  output logic             fwdB,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  function automatic logic [NREGS-1:0] onehot(input logic [AW-1:0] a);
    onehot    = '0;
    onehot[a] = 1'b1;
  endfunction

  // Returns {L, M, N}. PASS, SHL and SHR all pass operand A through.
  function automatic logic [11:0] lmn(input logic [2:0] op);
    case (op)
      OP_ADD:  lmn = 12'h686;
      OP_SUB:  lmn = 12'h946;
      OP_AND:  lmn = 12'h808;
      OP_OR:   lmn = 12'hE0E;
      OP_XOR:  lmn = 12'h606;
      default: lmn = 12'hC0C;
    endcase
  endfunction

  // Control state
  logic [1:0]     state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           first_q, first_d;
  logic           init_q;
  logic           wb_vld_q, wb_vld_d;

  // Instruction fields held in EX and WB (no reset needed: always qualified)
  logic [2:0]    ex_op_q;
  logic [1:0]    ex_opsel_q;
  logic [AW-1:0] ex_aaddr_q, ex_baddr_q, ex_waddr_q;
  logic [AW-1:0] wb_waddr_q;

  logic ex_vld, ex_last, accept, shift_in;

  assign ex_vld   = (state_q != IDLE);
  assign ex_last  = (state_q == EXEC) || ((state_q == SHIFT) && (cnt_q == SHW'(1)));
  // init_q keeps in_ready low while reset is asserted and until the first
  // clock edge after release.
  assign in_ready = init_q && ((state_q != SHIFT) || (cnt_q == SHW'(1)));
  assign accept   = in_valid && in_ready;
  // A zero-length shift is issued as a single-cycle PASS.
  assign shift_in = (opcode[2:1] == 2'b11) && (shamt != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = 1'b0;
    wb_vld_d = ex_last;
    if (accept) begin
      state_d = shift_in ? SHIFT : EXEC;
      cnt_d   = shift_in ? shamt : SHW'(1);
      first_d = shift_in;
    end else if (ex_last) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q - SHW'(1);
    end
  end

  // Stage boundary: issue -> EX / EX -> WB (control)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      init_q   <= 1'b0;
      wb_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      init_q   <= 1'b1;
      wb_vld_q <= wb_vld_d;
    end
  end

  // Stage boundary: issue -> EX / EX -> WB (instruction fields)
  always_ff @(posedge clk) begin
    if (accept) begin
      ex_op_q    <= opcode;
      ex_opsel_q <= opsel;
      ex_aaddr_q <= aaddr;
      ex_baddr_q <= baddr;
      ex_waddr_q <= waddr;
    end
    if (ex_last) begin
      wb_waddr_q <= ex_waddr_q;
    end
  end

  // EX outputs: decoded from registered state only.
  logic [11:0] lmn_ex;
  assign lmn_ex = ex_vld ? lmn(ex_op_q) : 12'h000;
  assign L      = lmn_ex[11:8];
  assign M      = lmn_ex[7:4];
  assign N      = lmn_ex[3:0];

  // A register is read on a single-cycle op and on the first shift cycle;
  // later shift cycles take the shifter feedback path instead.
  assign ARdEn = ((state_q == EXEC) || ((state_q == SHIFT) && first_q))
                 ? onehot(ex_aaddr_q) : '0;
  assign BRdEn = ex_vld ? onehot(ex_baddr_q) : '0;
  assign FBEn  = (state_q == SHIFT) && !first_q;

  assign ASelect    = ex_vld && !ex_opsel_q[1];
  assign zeroSelect = ex_vld &&  ex_opsel_q[1];
  assign BSelect    = ex_vld && !ex_opsel_q[0];
  assign DSelect    = ex_vld &&  ex_opsel_q[0];

  assign shl = (state_q == SHIFT) && (ex_op_q == OP_SHL);
  assign shr = (state_q == SHIFT) && (ex_op_q == OP_SHR);

  // WB only ever holds the previous instruction, so an instruction can never
  // forward against its own write address.
  assign fwdA = ex_vld && wb_vld_q && (ex_aaddr_q == wb_waddr_q);
  assign fwdB = ex_vld && wb_vld_q && (ex_baddr_q == wb_waddr_q);

  assign WriteEn = wb_vld_q ? onehot(wb_waddr_q) : '0;
  assign busy    = ex_vld || wb_vld_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // NREGS = 4 instance
  logic       v4;
  logic       rdy4;
  logic [2:0] op4;
  logic [1:0] sel4;
  logic [1:0] aa4, ba4, wa4;
  logic [2:0] sh4;
  logic [3:0] are4, bre4, we4;
  logic       fb4;
  logic [3:0] l4, m4, n4;
  logic       as4, bs4, ds4, zs4, shl4, shr4, fa4, fb_4, busy4;

  ctrl_pipe #(.NREGS(4), .SHW(3)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4),
    .opcode(op4), .opsel(sel4), .aaddr(aa4), .baddr(ba4), .waddr(wa4),
    .shamt(sh4), .ARdEn(are4), .BRdEn(bre4), .WriteEn(we4), .FBEn(fb4),
    .L(l4), .M(m4), .N(n4), .ASelect(as4), .BSelect(bs4), .DSelect(ds4),
    .zeroSelect(zs4), .shl(shl4), .shr(shr4), .fwdA(fa4), .fwdB(fb_4),
    .busy(busy4)
  );

  // NREGS = 16 instance
  logic        v16;
  logic        rdy16;
  logic [2:0]  op16;
  logic [1:0]  sel16;
  logic [3:0]  aa16, ba16, wa16;
  logic [2:0]  sh16;
  logic [15:0] are16, bre16, we16;
  logic        fbe16;
  logic [3:0]  l16, m16, n16;
  logic        as16, bs16, ds16, zs16, shl16, shr16, fa16, fb16, busy16;

  ctrl_pipe #(.NREGS(16), .SHW(3)) u16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
    .opcode(op16), .opsel(sel16), .aaddr(aa16), .baddr(ba16), .waddr(wa16),
    .shamt(sh16), .ARdEn(are16), .BRdEn(bre16), .WriteEn(we16), .FBEn(fbe16),
    .L(l16), .M(m16), .N(n16), .ASelect(as16), .BSelect(bs16), .DSelect(ds16),
    .zeroSelect(zs16), .shl(shl16), .shr(shr16), .fwdA(fa16), .fwdB(fb16),
    .busy(busy16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue4(input logic [2:0] op, input logic [1:0] sel, input logic [1:0] a,
                        input logic [1:0] b, input logic [1:0] w, input logic [2:0] sh);
    v4 = 1'b1; op4 = op; sel4 = sel; aa4 = a; ba4 = b; wa4 = w; sh4 = sh;
  endtask

  initial begin
    v4 = 1'b0; op4 = '0; sel4 = '0; aa4 = '0; ba4 = '0; wa4 = '0; sh4 = '0;
    v16 = 1'b0; op16 = '0; sel16 = '0; aa16 = '0; ba16 = '0; wa16 = '0; sh16 = '0;

    // Reset state
    #3;
    chk("rst4 in_ready", rdy4, 0);
    chk("rst4 outputs", |{are4, bre4, we4, fb4, l4, m4, n4, as4, bs4, ds4, zs4,
                          shl4, shr4, fa4, fb_4, busy4}, 0);
    chk("rst16 outputs", |{rdy16, are16, bre16, we16, fbe16, l16, m16, n16, as16, bs16,
                           ds16, zs16, shl16, shr16, fa16, fb16, busy16}, 0);
    #4 rst = 1'b0;
    tick();                                           // t=16
    chk("post-rst in_ready", rdy4, 1);
    chk("post-rst busy", busy4, 0);

    // ADD a=1 b=2 w=3 on u4; AND opsel=10 a=15 w=15 on u16
    issue4(3'b000, 2'b00, 2'd1, 2'd2, 2'd3, 3'd0);
    v16 = 1'b1; op16 = 3'b010; sel16 = 2'b10; aa16 = 4'd15; ba16 = 4'd0; wa16 = 4'd15;
    tick();                                           // ADD in EX
    v4 = 1'b0; v16 = 1'b0;
    chk("add ARdEn", are4, 4'b0010);
    chk("add BRdEn", bre4, 4'b0100);
    chk("add LMN", {l4, m4, n4}, 12'h686);
    chk("add sel A,B,D,Z", {as4, bs4, ds4, zs4}, 4'b1100);
    chk("add WriteEn", we4, 0);
    chk("add in_ready", rdy4, 1);
    chk("add busy", busy4, 1);
    chk("u16 sel A,B,D,Z", {as16, bs16, ds16, zs16}, 4'b0101);
    chk("u16 ARdEn", are16, 16'h8000);
    chk("u16 LMN", {l16, m16, n16}, 12'h808);
    tick();                                           // ADD in WB
    chk("add WB WriteEn", we4, 4'b1000);
    chk("add WB LMN", {l4, m4, n4}, 0);
    chk("add WB ARdEn", are4, 0);
    chk("add WB busy", busy4, 1);
    chk("u16 WriteEn", we16, 16'h8000);
    tick();
    chk("idle WriteEn", we4, 0);
    chk("idle busy", busy4, 0);

    // Back-to-back OR w=2 then XOR a=2 (forward)
    issue4(3'b011, 2'b11, 2'd0, 2'd1, 2'd2, 3'd0);
    tick();                                           // OR in EX
    chk("or LMN", {l4, m4, n4}, 12'hE0E);
    chk("or sel A,B,D,Z", {as4, bs4, ds4, zs4}, 4'b0011);
    chk("or fwdA", fa4, 0);
    chk("or in_ready", rdy4, 1);
    issue4(3'b100, 2'b00, 2'd2, 2'd3, 2'd0, 3'd0);
    tick();                                           // XOR in EX, OR in WB
    v4 = 1'b0;
    chk("xor fwdA", fa4, 1);
    chk("xor fwdB", fb_4, 0);
    chk("xor WriteEn", we4, 4'b0100);
    chk("xor LMN", {l4, m4, n4}, 12'h606);
    chk("xor ARdEn", are4, 4'b0100);
    chk("xor in_ready", rdy4, 1);
    tick();                                           // XOR in WB
    chk("xor WB WriteEn", we4, 4'b0001);
    chk("xor WB fwdA", fa4, 0);

    // SHL shamt=3 a=1 w=1
    issue4(3'b110, 2'b00, 2'd1, 2'd0, 2'd1, 3'd3);
    tick();                                           // shift cycle 1
    v4 = 1'b0;
    chk("shl1 FBEn", fb4, 0);
    chk("shl1 ARdEn", are4, 4'b0010);
    chk("shl1 shl", shl4, 1);
    chk("shl1 in_ready", rdy4, 0);
    chk("shl1 fwdA", fa4, 0);
    chk("shl1 LMN", {l4, m4, n4}, 12'hC0C);
    chk("shl1 WriteEn", we4, 0);
    tick();                                           // shift cycle 2
    chk("shl2 FBEn", fb4, 1);
    chk("shl2 ARdEn", are4, 0);
    chk("shl2 shl", shl4, 1);
    chk("shl2 in_ready", rdy4, 0);
    chk("shl2 WriteEn", we4, 0);
    tick();                                           // shift cycle 3
    chk("shl3 FBEn", fb4, 1);
    chk("shl3 ARdEn", are4, 0);
    chk("shl3 shl", shl4, 1);
    chk("shl3 in_ready", rdy4, 1);
    chk("shl3 WriteEn", we4, 0);
    tick();                                           // WB
    chk("shl WB WriteEn", we4, 4'b0010);
    chk("shl WB shl", shl4, 0);
    chk("shl WB FBEn", fb4, 0);
    chk("shl WB fwdA", fa4, 0);
    tick();
    chk("shl after WriteEn", we4, 0);

    // SHR shamt=0 behaves as PASS
    issue4(3'b111, 2'b00, 2'd2, 2'd0, 2'd3, 3'd0);
    tick();
    v4 = 1'b0;
    chk("shr0 shr", shr4, 0);
    chk("shr0 LMN", {l4, m4, n4}, 12'hC0C);
    chk("shr0 ARdEn", are4, 4'b0100);
    chk("shr0 FBEn", fb4, 0);
    chk("shr0 in_ready", rdy4, 1);
    tick();
    chk("shr0 WriteEn", we4, 4'b1000);

    // SHR shamt=5 aborted by reset in cycle 2
    issue4(3'b111, 2'b00, 2'd0, 2'd0, 2'd2, 3'd5);
    tick();                                           // cycle 1
    v4 = 1'b0;
    chk("shr5 c1 shr", shr4, 1);
    chk("shr5 c1 in_ready", rdy4, 0);
    tick();                                           // cycle 2
    chk("shr5 c2 FBEn", fb4, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort outputs", |{are4, bre4, we4, fb4, l4, m4, n4, as4, bs4, ds4, zs4,
                           shl4, shr4, fa4, fb_4, busy4}, 0);
    chk("abort in_ready", rdy4, 0);
    #2 rst = 1'b0;
    tick();
    chk("abort rel in_ready", rdy4, 1);
    chk("abort rel WriteEn", we4, 0);
    chk("abort rel busy", busy4, 0);
    tick();
    chk("abort rel2 WriteEn", we4, 0);
    tick();
    chk("abort rel3 WriteEn", we4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
